grf: RTL and testbench
======================

Name: grf

Overview:
- General-purpose register file sitting directly upstream of the ALU. It supplies operands A (RD1) and B (RD2).
- 32 x 32-bit registers, two combinational read ports and one synchronous write port.
- Register $0 is hardwired to zero.
- The writeback path (ALU result C or other source) returns through WD/A3/WE.

Parameters:
- WIDTH, 32, data width of each register and of RD1/RD2/WD
- ADDR_W, 5, address width; register count = 2**ADDR_W
- RESET_VAL, 0, value loaded into every register on reset

Ports:
- clk  input  1  system clock; all writes occur on rising edge
- reset  input  1  asynchronous, active-high; clears all registers immediately
- WE  input  1  write enable, sampled at rising edge of clk
- A1  input  ADDR_W  read address, port 1 (feeds ALU A)
- A2  input  ADDR_W  read address, port 2 (feeds ALU B)
- A3  input  ADDR_W  write address
- WD  input  WIDTH  write data
- RD1  output  WIDTH  contents of register A1
- RD2  output  WIDTH  contents of register A2

Behaviour:
- Clock and reset: one clock `clk`; reset port `reset` is asynchronous and active-high.
- Storage: array of 2**ADDR_W registers, WIDTH bits each.
- Reset:
  - On reset rising (async, not waiting for clk), every register becomes RESET_VAL; register 0 is always 0 regardless of RESET_VAL.
  - While reset is high, writes are suppressed and RD1/RD2 read RESET_VAL (0 for address 0).
- Write:
  - At posedge clk with reset low and WE=1 and A3!=0, register[A3] <= WD.
  - WE=0 or A3=0: no state change.
  - Write latency is 1 cycle; the new value is visible on RD ports after the edge.
- Read:
  - Purely combinational: RD1 = (A1==0) ? 0 : register[A1]; RD2 likewise with A2.
  - Zero cycles latency; outputs change within the same cycle as A1/A2 changes.
- Register 0 reads 0 at all times, including immediately after an attempted write to it.
- Same-cycle read/write of the same address (no bypass): RD shows the old value until the edge, then the new value.
- A1==A2: both ports return identical data.
- Reset asserted in the same cycle as a write: reset wins and the register ends at RESET_VAL. Reset deasserted mid-cycle: the next posedge with WE performs a normal write.
- No X propagation: every register has a defined value after the first reset. Reads before the first reset are don't-care and must not be checked.

Optional Feature:
- Macro GRF_BYPASS_EN.
- Defined: internal write-forwarding.
  - If reset low and WE=1 and A3!=0 and A1==A3, RD1 = WD combinationally. RD2 is forwarded the same way when A2==A3.
  - Register 0 is never forwarded.
  - The stored value still updates at the edge as normal.
- Not defined: no forwarding; reads always return stored contents as described above.

Test Plan:
- Reset then read all: assert reset, sweep A1/A2 over 0..31 -> RD1=RD2=0 everywhere.
- Basic write/read: WE=1, A3=5, WD=32'h1234_5678, one edge; A1=5, A2=5 -> RD1=RD2=32'h1234_5678 after the edge; register 6 still 0.
- $0 protection: WE=1, A3=0, WD=32'hFFFF_FFFF, edge; A1=0 -> RD1=0.
- Same-cycle hazard: register 7 holds 32'hA; drive WE=1, A3=7, WD=32'hB with A1=7.
  - Before edge: RD1=32'hA (32'hB with GRF_BYPASS_EN).
  - After edge: 32'hB in both builds.
- Async reset mid-operation: registers 1..31 loaded with k*3; pulse reset between edges -> all RD immediately 0 without any clk edge.
  - Also: a WE=1 write to reg 9 (WD=32'h55) coincident with reset -> reg 9 = 0.
- ALU integration: write reg1=32'h8000_0000 and reg2=4; A1=1, A2=2 into ALU with ALUOp=3'b101 -> C=32'hF800_0000. With ALUOp=3'b100 -> C=32'h0800_0000.

Source files
------------

// File: rtl/grf.sv
// grf: 32 x 32-bit general-purpose register file, two combinational read ports, one write port.
// Optional write-to-read forwarding is enabled by defining GRF_BYPASS_EN.
module grf #(
    parameter int               WIDTH     = 32,
    parameter int               ADDR_W    = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [WIDTH-1:0]  WD,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_r [NREG];
    logic             wr_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;

    // Write qualifier: register 0 is never written so it stays hardwired to zero
    always_comb begin
        wr_en_s = WE && (A3 != {ADDR_W{1'b0}});
    end

    // Storage array with asynchronous clear; reset wins over a coincident write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_r[0] <= {WIDTH{1'b0}};
            for (int i = 1; i < NREG; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else if (wr_en_s) begin
            regs_r[A3] <= WD;
        end else begin
            regs_r[A3] <= regs_r[A3];
        end
    end

    // Read port 1 (ALU operand A), forwarded from the write port when enabled
    always_comb begin
        rd1_s = {WIDTH{1'b0}};
        if (A1 == {ADDR_W{1'b0}}) begin
            rd1_s = {WIDTH{1'b0}};
`ifdef GRF_BYPASS_EN
        end else if (!reset && wr_en_s && (A1 == A3)) begin
            rd1_s = WD;
`endif
        end else begin
            rd1_s = regs_r[A1];
        end
    end

    // Read port 2 (ALU operand B), same rules as port 1
    always_comb begin
        rd2_s = {WIDTH{1'b0}};
        if (A2 == {ADDR_W{1'b0}}) begin
            rd2_s = {WIDTH{1'b0}};
`ifdef GRF_BYPASS_EN
        end else if (!reset && wr_en_s && (A2 == A3)) begin
            rd2_s = WD;
`endif
        end else begin
            rd2_s = regs_r[A2];
        end
    end

    assign RD1 = rd1_s;
    assign RD2 = rd2_s;

endmodule

// File: tb/tb_grf.sv
// tb_grf: directed table-driven checks for grf plus hand-written reset and hazard sequences.
module tb_grf;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int total;
    int bad;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [8];

    grf dut (
        .clk   (clk),
        .reset (reset),
        .WE    (WE),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD    (WD),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ALU model for operand integration: 101 arithmetic right shift, 100 logical.
    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b101:  alu = $unsigned($signed(a) >>> b[4:0]);
            3'b100:  alu = a >> b[4:0];
            default: alu = 32'h0;
        endcase
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1; A3 = a; WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    logic [31:0] exp_before;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        WE = 1'b0; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD = 32'h0;

        vecs[0] = '{1'b1, 5'd5,  32'h1234_5678, 5'd5,  5'd6,  32'h1234_5678, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'h1234_5678};
        vecs[2] = '{1'b0, 5'd6,  32'hDEAD_BEEF, 5'd6,  5'd5,  32'h0,         32'h1234_5678};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 5'd5,  32'h0000_0001, 5'd5,  5'd31, 32'h0000_0001, 32'hCAFE_F00D};
        vecs[5] = '{1'b1, 5'd7,  32'h0000_000A, 5'd7,  5'd0,  32'h0000_000A, 32'h0};
        vecs[6] = '{1'b1, 5'd1,  32'h8000_0000, 5'd1,  5'd7,  32'h8000_0000, 32'h0000_000A};
        vecs[7] = '{1'b1, 5'd2,  32'h0000_0004, 5'd1,  5'd2,  32'h8000_0000, 32'h0000_0004};

        // Reset state: every address reads zero on both ports while reset is held
        @(posedge clk);
        #2;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            chk("reset_rd1", RD1, 32'h0);
            chk("reset_rd2", RD2, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Table: write on one edge, then check both read ports
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            WE = vecs[v].we; A3 = vecs[v].a3; WD = vecs[v].wd;
            A1 = vecs[v].a1; A2 = vecs[v].a2;
            @(posedge clk);
            #1;
            WE = 1'b0;
            #1;
            chk($sformatf("vec%0d_rd1", v), RD1, vecs[v].exp1);
            chk($sformatf("vec%0d_rd2", v), RD2, vecs[v].exp2);
        end

        // Operands into the ALU model (A1=1, A2=2 from the last vector)
        chk("alu_sra", alu(RD1, RD2, 3'b101), 32'hF800_0000);
        chk("alu_srl", alu(RD1, RD2, 3'b100), 32'h0800_0000);

        // Same-cycle read/write of register 7 (holds 0xA)
`ifdef GRF_BYPASS_EN
        exp_before = 32'h0000_000B;
`else
        exp_before = 32'h0000_000A;
`endif
        @(negedge clk);
        WE = 1'b1; A3 = 5'd7; WD = 32'h0000_000B; A1 = 5'd7; A2 = 5'd0;
        #1;
        chk("hazard_before", RD1, exp_before);
        chk("hazard_a2_zero", RD2, 32'h0);
        @(posedge clk);
        #1;
        WE = 1'b0;
        #1;
        chk("hazard_after", RD1, 32'h0000_000B);

        // Register 0 is never forwarded even with a live write to it
        @(negedge clk);
        WE = 1'b1; A3 = 5'd0; WD = 32'h1357_9BDF; A1 = 5'd0;
        #1;
        chk("zero_no_fwd", RD1, 32'h0);
        @(posedge clk);
        #1;
        WE = 1'b0;
        #1;
        chk("zero_after_wr", RD1, 32'h0);

        // Load k*3 into registers 1..31
        for (int k = 1; k < 32; k++) begin
            wr(5'(k), 32'(k * 3));
        end
        A1 = 5'd10; A2 = 5'd31;
        #1;
        chk("load_r10", RD1, 32'd30);
        chk("load_r31", RD2, 32'd93);

        // Asynchronous reset pulse between edges: reads go to zero with no clock edge
        @(posedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(i);
            #1;
            chk("async_rd1", RD1, 32'h0);
            chk("async_rd2", RD2, 32'h0);
        end
        reset = 1'b0;

        // Write to reg 9 coincident with reset: reset wins
        @(negedge clk);
        WE = 1'b1; A3 = 5'd9; WD = 32'h0000_0055; A1 = 5'd9;
        reset = 1'b1;
        #1;
        chk("rst_wr_nofwd", RD1, 32'h0);
        @(posedge clk);
        #1;
        WE = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_wins_r9", RD1, 32'h0);

        // After reset release the next enabled edge writes normally
        wr(5'd9, 32'h0000_0055);
        A1 = 5'd9; A2 = 5'd9;
        #1;
        chk("post_rst_rd1", RD1, 32'h0000_0055);
        chk("post_rst_rd2", RD2, 32'h0000_0055);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
